// File: rtl/mealy_multi_pattern_detector_if.sv
// rtl/mealy_multi_pattern_detector_if.sv - port bundle for the serial multi-pattern detector (HIT_COUNT_EN adds hit_clr/hit_cnt)
interface mealy_multi_pattern_detector_if #(
  parameter int LEN = 4
);
  logic           in;
  logic           in_valid;
  logic           mode;
  logic           pat_we;
  logic [1:0]     pat_sel;
  logic [LEN-1:0] pat_data;
  logic           dec;
  logic [1:0]     dec_id;
  logic           frame_done;
`ifdef HIT_COUNT_EN
  logic           hit_clr;
  logic [7:0]     hit_cnt;
`endif

  // stimulus side: drives the serial stream and pattern writes, observes detections
  modport master (
    output in, in_valid, mode, pat_we, pat_sel, pat_data,
`ifdef HIT_COUNT_EN
    output hit_clr,
    input  hit_cnt,
`endif
    input  dec, dec_id, frame_done
  );

  // detector side
  modport slave (
    input  in, in_valid, mode, pat_we, pat_sel, pat_data,
`ifdef HIT_COUNT_EN
    input  hit_clr,
    output hit_cnt,
`endif
    output dec, dec_id, frame_done
  );
endinterface

// File: rtl/mealy_multi_pattern_detector.sv
// rtl/mealy_multi_pattern_detector.sv - Mealy serial detector matching a LEN-bit window against NPAT programmable slots (optional HIT_COUNT_EN hit counter)
module mealy_multi_pattern_detector #(
  parameter int LEN  = 4,
  parameter int NPAT = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mealy_multi_pattern_detector_if.slave bus
);

  localparam int            CW     = $clog2(LEN);
  localparam logic [CW-1:0] LAST   = CW'(LEN - 1);
  localparam logic [2:0]    NPAT_W = 3'(NPAT);

  // Window state: the last LEN-1 accepted bits plus position counters
  logic [LEN-2:0]  hist;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   fill;
  logic            mode_q;

  // Pattern slots and their enables
  logic [LEN-1:0]  pat [NPAT];
  logic [NPAT-1:0] en;

  logic            write_ok;
  logic            mode_chg;
  logic            bit_ok;
  logic            window_full;
  logic            any_hit;
  logic [LEN-1:0]  window;
  logic [NPAT-1:0] hit;
  logic [1:0]      hit_id;

  // Qualify the incoming bit: a slot write or a mode switch both restart the window and drop the bit
  always_comb begin
    write_ok = bus.pat_we && ({1'b0, bus.pat_sel} < NPAT_W);
    mode_chg = bus.mode != mode_q;
    bit_ok   = bus.in_valid && !write_ok && !mode_chg;
  end

  assign window = {hist, bus.in};

  // Compare the live window against every enabled slot
  always_comb begin
    hit = '0;
    for (int i = 0; i < NPAT; i++) begin
      hit[i] = en[i] && (pat[i] == window);
    end
  end

  // Lowest matching slot index wins
  always_comb begin
    hit_id = '0;
    for (int i = NPAT - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_id = 2'(i);
      end
    end
  end

  assign any_hit = |hit;

  // Framed mode completes a window only at the frame's last bit; sliding mode once the window has filled
  always_comb begin
    window_full = mode_q ? (fill == LAST) : (cnt == LAST);
  end

  // Mealy outputs, all zero unless this cycle's bit is accepted and closes a window
  always_comb begin
    bus.dec        = 1'b0;
    bus.dec_id     = 2'd0;
    bus.frame_done = 1'b0;
    if (bit_ok && window_full) begin
      bus.dec        = any_hit;
      bus.dec_id     = any_hit ? hit_id : 2'd0;
      bus.frame_done = !mode_q;
    end
  end

  // History, frame counter, fill counter and registered mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist   <= '0;
      cnt    <= '0;
      fill   <= '0;
      mode_q <= 1'b0;
    end else begin
      mode_q <= bus.mode;
      if (write_ok || mode_chg) begin
        hist <= '0;
        cnt  <= '0;
        fill <= '0;
      end else if (bit_ok) begin
        hist <= window[LEN-2:0];
        cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        fill <= (fill == LAST) ? fill : fill + 1'b1;
      end
    end
  end

  // Pattern slot writes; out-of-range selects never match any slot and are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en <= '0;
      for (int i = 0; i < NPAT; i++) begin
        pat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NPAT; i++) begin
        if (write_ok && (bus.pat_sel == 2'(i))) begin
          pat[i] <= bus.pat_data;
          en[i]  <= 1'b1;
        end
      end
    end
  end

`ifdef HIT_COUNT_EN
  logic [7:0] hit_cnt_q;

  // Saturating detection counter; clear takes priority over a same-cycle hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q <= 8'd0;
    end else if (bus.hit_clr) begin
      hit_cnt_q <= 8'd0;
    end else if (bus.dec && (hit_cnt_q != 8'hff)) begin
      hit_cnt_q <= hit_cnt_q + 8'd1;
    end
  end

  assign bus.hit_cnt = hit_cnt_q;
`else
  // no hit counter in this build
`endif

endmodule

// File: tb/tb_mealy_multi_pattern_detector.sv
// tb/tb_mealy_multi_pattern_detector.sv - self-checking bench for mealy_multi_pattern_detector (LEN=4, NPAT=3)
module tb_mealy_multi_pattern_detector;
  localparam int LEN  = 4;
  localparam int NPAT = 3;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mealy_multi_pattern_detector_if #(.LEN(LEN)) bus ();

  mealy_multi_pattern_detector #(.LEN(LEN), .NPAT(NPAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of accepted bits since the last restart, slot contents, mode
  int  m_pat [4];
  bit  m_en  [4];
  bit  m_mode;
  int  m_bits[$];
  int  m_n;
  int  m_hits;
  bit  e_dec, e_fd, wr, mc, acc, full;
  int  e_id, w;

  // Compare every cycle at the falling edge, then advance the model to the next rising edge
  always @(negedge clk) begin
    e_dec = 1'b0; e_fd = 1'b0; e_id = 0;
    wr = 1'b0; mc = 1'b0; acc = 1'b0;
    if (rst_n) begin
      wr  = bus.pat_we && (int'(bus.pat_sel) < NPAT);
      mc  = bus.mode != m_mode;
      acc = bus.in_valid && !wr && !mc;
      if (acc) begin
        full = m_mode ? (m_n >= LEN - 1) : ((m_n % LEN) == LEN - 1);
        if (full) begin
          w = int'(bus.in);
          for (int k = 0; k < LEN - 1; k++) begin
            w = w | (m_bits[m_bits.size() - 1 - k] << (k + 1));
          end
          e_fd = !m_mode;
          for (int i = NPAT - 1; i >= 0; i--) begin
            if (m_en[i] && (m_pat[i] == w)) begin
              e_dec = 1'b1;
              e_id  = i;
            end
          end
        end
      end
    end
    chk("model_dec", 32'(bus.dec), 32'(e_dec));
    chk("model_dec_id", 32'(bus.dec_id), 32'(e_id));
    chk("model_frame_done", 32'(bus.frame_done), 32'(e_fd));
`ifdef HIT_COUNT_EN
    chk("model_hit_cnt", 32'(bus.hit_cnt), 32'(m_hits));
`endif
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_pat[i] = 0;
        m_en[i]  = 1'b0;
      end
      m_mode = 1'b0;
      m_bits.delete();
      m_n    = 0;
      m_hits = 0;
    end else begin
      if (wr) begin
        m_pat[int'(bus.pat_sel)] = int'(bus.pat_data);
        m_en[int'(bus.pat_sel)]  = 1'b1;
      end
      if (wr || mc) begin
        m_bits.delete();
        m_n = 0;
      end else if (acc) begin
        m_bits.push_back(int'(bus.in));
        if (m_bits.size() > LEN) void'(m_bits.pop_front());
        m_n++;
      end
      m_mode = bus.mode;
`ifdef HIT_COUNT_EN
      if (bus.hit_clr) m_hits = 0;
      else if (e_dec && m_hits < 255) m_hits++;
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One valid bit with hand-computed expectations
  task automatic bitv(input bit b, input bit ed, input int eid, input bit efd);
    bus.in_valid = 1'b1;
    bus.in       = b;
    #3;
    chk("lit_dec", 32'(bus.dec), 32'(ed));
    chk("lit_dec_id", 32'(bus.dec_id), 32'(eid));
    chk("lit_frame_done", 32'(bus.frame_done), 32'(efd));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic wr_slot(input logic [1:0] sel, input logic [3:0] data);
    bus.pat_we   = 1'b1;
    bus.pat_sel  = sel;
    bus.pat_data = data;
    tick();
    bus.pat_we   = 1'b0;
  endtask

  task automatic load_default();
    wr_slot(2'd0, 4'b1011);
    wr_slot(2'd1, 4'b1010);
    wr_slot(2'd2, 4'b0011);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n        = 1'b0;
    bus.in       = 1'b1;
    bus.in_valid = 1'b1;
    bus.mode     = 1'b0;
    bus.pat_we   = 1'b0;
    bus.pat_sel  = 2'd0;
    bus.pat_data = '0;
`ifdef HIT_COUNT_EN
    bus.hit_clr  = 1'b0;
`endif
    tick();
    tick();
    chk("reset_dec", 32'(bus.dec), 32'd0);
    chk("reset_frame_done", 32'(bus.frame_done), 32'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    tick();

    // no slot enabled yet: a full frame never matches
    bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(1, 0, 0, 1);
    load_default();

    // framed 1011 -> slot 0
    bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(1, 1, 0, 1);
    // framed 0011 then 0010
    bitv(0, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(1, 1, 2, 1);
    bitv(0, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(0, 0, 0, 1);
    // invalid gaps inside a frame
    bitv(1, 0, 0, 0); idle(3); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(0, 1, 1, 1);

    // sliding mode, overlapping matches
    bus.mode = 1'b1;
    idle(1);
    bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(1, 1, 0, 0);
    bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(1, 1, 0, 0);
    // two slots with the same pattern: lowest index reported
    wr_slot(2'd2, 4'b1011);
    bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(1, 1, 0, 0);

    // switch back to framed with a valid bit: that bit is dropped
    bus.mode = 1'b0;
    bitv(1, 0, 0, 0);
    bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(1, 1, 0, 1);
    wr_slot(2'd2, 4'b0011);

    // slot write collides with a valid bit mid-frame: bit dropped, frame restarts
    bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0);
    bus.pat_we   = 1'b1;
    bus.pat_sel  = 2'd1;
    bus.pat_data = 4'b1010;
    bitv(1, 0, 0, 0);
    bus.pat_we   = 1'b0;
    bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(0, 1, 1, 1);

    // out-of-range slot write is ignored
    wr_slot(2'd3, 4'b1111);
    bitv(1, 0, 0, 0); bitv(1, 0, 0, 0); bitv(1, 0, 0, 0); bitv(1, 0, 0, 1);

    // reset mid-frame discards the partial frame
    bitv(1, 0, 0, 0); bitv(0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    chk("midreset_dec", 32'(bus.dec), 32'd0);
    rst_n = 1'b1;
    load_default();
    bitv(1, 0, 0, 0); bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(0, 0, 0, 1);
    bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(1, 1, 0, 1);

`ifdef HIT_COUNT_EN
    for (int f = 0; f < 300; f++) begin
      bitv(1, 0, 0, 0); bitv(0, 0, 0, 0); bitv(1, 0, 0, 0); bitv(1, 1, 0, 1);
    end
    chk("hit_cnt_saturated", 32'(bus.hit_cnt), 32'd255);
    bus.hit_clr = 1'b1;
    tick();
    bus.hit_clr = 1'b0;
    chk("hit_cnt_cleared", 32'(bus.hit_cnt), 32'd0);
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
